// File: rtl/nrisc_pkg.sv
// Shared NRISC writeback types: data width, reserved register indices, context FSM states, writeback entry.
// No logic or latency of its own; no flow control.
package nrisc_pkg;

  localparam int TAM = 16;

  localparam logic [3:0] REG_ZERO = 4'd0;
  localparam logic [3:0] REG_R1   = 4'd1;

  typedef enum logic [1:0] {
    USR       = 2'd0,
    DRAIN_IN  = 2'd1,
    FIRQ      = 2'd2,
    DRAIN_OUT = 2'd3
  } state_t;

  typedef struct packed {
    logic [3:0]     rfd;
    logic [TAM-1:0] data;
  } wb_entry;

  // r0 and r1 are not backed by the register file, so writes to them are dropped.
  function automatic logic is_target(input logic [3:0] rfd);
    return (rfd != REG_ZERO) && (rfd != REG_R1);
  endfunction

endpackage

// File: rtl/nrisc_wb_fifo.sv
// Synchronous FIFO of writeback entries; the head is visible on o_data combinationally, pop takes effect at the edge.
// Pushes are ignored while full; the caller must throttle its producer from o_count/o_full.
module nrisc_wb_fifo
  import nrisc_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  wb_entry                i_data,
  input  logic                   i_pop,
  output wb_entry                o_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int PW = $clog2(DEPTH);

  wb_entry         r_mem [DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [PW:0]     r_count;
  logic            w_push;
  logic            w_pop;

  assign o_full  = (r_count == (PW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rptr];

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

endmodule

// File: rtl/nrisc_wb_arbiter.sv
// Register-file writeback arbiter plus USR/FIRQ context sequencer; ULA writes land 1 cycle later, loads 2 (1 when NRISC_WB_BYPASS_EN bypasses an empty FIFO).
// ULA has no backpressure and always wins; MEM_WB_ready drops when the load FIFO is full or a context drain is in progress.
module nrisc_wb_arbiter
  import nrisc_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ULA_WB_valid,
  input  logic [3:0]     ULA_WB_rfd,
  input  logic [TAM-1:0] ULA_WB_data,
  input  logic           MEM_WB_valid,
  output logic           MEM_WB_ready,
  input  logic [3:0]     MEM_WB_rfd,
  input  logic [TAM-1:0] MEM_WB_data,
  input  logic           IRQ_req,
  input  logic           IRQ_ret,
  output logic           IRQ_ack,
  output logic           REG_Write,
  output logic [3:0]     REG_RFD,
  output logic [TAM-1:0] REG_D,
  output logic           REG_Interrupt_flag,
  output logic           busy
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t         r_state;
  state_t         w_state_nxt;
  logic           w_switch;
  logic           w_drained;

  logic           r_mem_rdy;
  logic           r_wr;
  logic [3:0]     r_rfd;
  logic [TAM-1:0] r_d;
  logic           r_ack;
  logic           r_flag;
  logic           r_busy;

  logic           w_ula_hit;
  logic           w_mem_hs;
  logic           w_mem_keep;
  logic           w_bypass;
  logic           w_push;
  logic           w_pop;
  logic           w_full;
  logic           w_empty;
  wb_entry        w_head;
  wb_entry        w_mem_entry;
  logic [CW-1:0]  w_count;
  logic [CW-1:0]  w_count_nxt;
  logic           w_wr_nxt;
  logic [3:0]     w_rfd_nxt;
  logic [TAM-1:0] w_d_nxt;

  assign w_ula_hit   = ULA_WB_valid && is_target(ULA_WB_rfd);
  assign w_mem_hs    = MEM_WB_valid && r_mem_rdy;
  assign w_mem_keep  = w_mem_hs && is_target(MEM_WB_rfd);
  assign w_mem_entry = '{rfd: MEM_WB_rfd, data: MEM_WB_data};

`ifdef NRISC_WB_BYPASS_EN
  assign w_bypass = w_mem_keep && w_empty && !w_ula_hit;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push = w_mem_keep && !w_bypass;
  assign w_pop  = !w_ula_hit && !w_empty;

  nrisc_wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_mem_entry),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign w_count_nxt = w_count + CW'(w_push && !w_full) - CW'(w_pop);

  always_comb begin
    w_wr_nxt  = 1'b0;
    w_rfd_nxt = r_rfd;
    w_d_nxt   = r_d;
    if (w_ula_hit) begin
      w_wr_nxt  = 1'b1;
      w_rfd_nxt = ULA_WB_rfd;
      w_d_nxt   = ULA_WB_data;
    end else if (w_pop) begin
      w_wr_nxt  = 1'b1;
      w_rfd_nxt = w_head.rfd;
      w_d_nxt   = w_head.data;
    end else if (w_bypass) begin
      w_wr_nxt  = 1'b1;
      w_rfd_nxt = MEM_WB_rfd;
      w_d_nxt   = MEM_WB_data;
    end
  end

  // Switching only when nothing is queued, issuing or arriving guarantees the next cycle has no write, so the flag never moves under a write.
  assign w_drained = w_empty && !ULA_WB_valid && !r_wr;

  always_comb begin
    w_state_nxt = r_state;
    w_switch    = 1'b0;
    case (r_state)
      USR:       if (IRQ_req) w_state_nxt = DRAIN_IN;
      DRAIN_IN:  if (w_drained) begin
                   w_state_nxt = FIRQ;
                   w_switch    = 1'b1;
                 end
      FIRQ:      if (IRQ_ret) w_state_nxt = DRAIN_OUT;
      DRAIN_OUT: if (w_drained) begin
                   w_state_nxt = USR;
                   w_switch    = 1'b1;
                 end
      default:   w_state_nxt = USR;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= USR;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem_rdy <= 1'b0;
      r_wr      <= 1'b0;
      r_rfd     <= '0;
      r_d       <= '0;
      r_ack     <= 1'b0;
      r_flag    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_mem_rdy <= (w_count_nxt != CW'(FIFO_DEPTH)) &&
                   ((w_state_nxt == USR) || (w_state_nxt == FIRQ));
      r_wr      <= w_wr_nxt;
      r_rfd     <= w_rfd_nxt;
      r_d       <= w_d_nxt;
      r_ack     <= w_switch;
      if (w_switch) r_flag <= (r_state == DRAIN_IN);
      r_busy    <= (w_count_nxt != '0) || w_wr_nxt;
    end
  end

  assign MEM_WB_ready       = r_mem_rdy;
  assign REG_Write          = r_wr;
  assign REG_RFD            = r_rfd;
  assign REG_D              = r_d;
  assign IRQ_ack            = r_ack;
  assign REG_Interrupt_flag = r_flag;
  assign busy               = r_busy;

endmodule

// File: tb/tb_nrisc_wb_arbiter.sv
// Bench for nrisc_wb_arbiter: vector table plus multi-cycle sequences, with a write-order scoreboard.
// Honours NRISC_WB_BYPASS_EN in its reference model.
module tb_nrisc_wb_arbiter;

`ifdef NRISC_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ULA_WB_valid = 1'b0;
  logic [3:0]  ULA_WB_rfd = 4'd0;
  logic [15:0] ULA_WB_data = 16'h0;
  logic        MEM_WB_valid = 1'b0;
  logic        MEM_WB_ready;
  logic [3:0]  MEM_WB_rfd = 4'd0;
  logic [15:0] MEM_WB_data = 16'h0;
  logic        IRQ_req = 1'b0;
  logic        IRQ_ret = 1'b0;
  logic        IRQ_ack;
  logic        REG_Write;
  logic [3:0]  REG_RFD;
  logic [15:0] REG_D;
  logic        REG_Interrupt_flag;
  logic        busy;

  nrisc_wb_arbiter #(.FIFO_DEPTH(2)) dut (
    .clk                (clk),
    .rst                (rst),
    .ULA_WB_valid       (ULA_WB_valid),
    .ULA_WB_rfd         (ULA_WB_rfd),
    .ULA_WB_data        (ULA_WB_data),
    .MEM_WB_valid       (MEM_WB_valid),
    .MEM_WB_ready       (MEM_WB_ready),
    .MEM_WB_rfd         (MEM_WB_rfd),
    .MEM_WB_data        (MEM_WB_data),
    .IRQ_req            (IRQ_req),
    .IRQ_ret            (IRQ_ret),
    .IRQ_ack            (IRQ_ack),
    .REG_Write          (REG_Write),
    .REG_RFD            (REG_RFD),
    .REG_D              (REG_D),
    .REG_Interrupt_flag (REG_Interrupt_flag),
    .busy               (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [19:0] mq[$];
  logic [19:0] exq[$];
  logic [15:0] rf [16];

  typedef struct {
    logic        uv;
    logic [3:0]  ur;
    logic [15:0] ud;
    logic        mv;
    logic [3:0]  mr;
    logic [15:0] md;
    logic        e_hs;
    logic        e_w1;
    logic        e_w2;
  } vec_t;

  vec_t tbl [9];

  function automatic bit tgt(input logic [3:0] r);
    return r > 4'd1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One cycle of stimulus; the reference model decides which write is due next cycle.
  task automatic step(input logic uv, input logic [3:0] ur, input logic [15:0] ud,
                      input logic mv, input logic [3:0] mr, input logic [15:0] md,
                      output logic hs);
    logic byp;
    ULA_WB_valid = uv;
    ULA_WB_rfd   = ur;
    ULA_WB_data  = ud;
    MEM_WB_valid = mv;
    MEM_WB_rfd   = mr;
    MEM_WB_data  = md;
    @(negedge clk);
    hs  = mv && MEM_WB_ready;
    byp = 1'b0;
    if (uv && tgt(ur)) exq.push_back({ur, ud});
    else if (mq.size() != 0) exq.push_back(mq.pop_front());
    else if (BYP && hs && tgt(mr)) begin
      exq.push_back({mr, md});
      byp = 1'b1;
    end
    if (hs && tgt(mr) && !byp) mq.push_back({mr, md});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(output logic hs);
    step(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, hs);
  endtask

  always @(negedge clk) begin : mon
    logic [19:0] e;
    if (rst && REG_Write) begin
      if (exq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wb_unexpected: got rfd=%0d d=%0h, expected no write", REG_RFD, REG_D);
      end else begin
        e = exq.pop_front();
        chk("wb_entry", {12'h0, REG_RFD, REG_D}, {12'h0, e});
      end
      rf[REG_RFD] = REG_D;
    end
  end

  logic prev_flag = 1'b0;
  always @(negedge clk) begin
    if (!rst) prev_flag = 1'b0;
    else begin
      if (REG_Interrupt_flag != prev_flag)
        chk("flag_change_clean", {30'h0, REG_Write, IRQ_ack}, 32'h1);
      prev_flag = REG_Interrupt_flag;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic hs;
    int   k;
    int   lat;
    int   acks;
    bit   got;

    tbl[0] = '{1'b1, 4'd5,  16'h1234, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 4'd15, 16'hFFFF, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 4'd1,  16'h1111, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 4'd0,  16'h2222, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 4'd0,  16'h0000, 1'b1, 4'd7, 16'h0BEE, 1'b1, BYP,  !BYP};
    tbl[5] = '{1'b1, 4'd1,  16'h3333, 1'b1, 4'd0, 16'h4444, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 4'd3,  16'h0303, 1'b1, 4'd2, 16'h0202, 1'b1, 1'b1, 1'b1};
    tbl[7] = '{1'b1, 4'd9,  16'hAAAA, 1'b1, 4'd9, 16'h5555, 1'b1, 1'b1, 1'b1};
    tbl[8] = '{1'b1, 4'd0,  16'h6666, 1'b1, 4'd1, 16'h7777, 1'b1, 1'b0, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_write", REG_Write, 0);
    chk("rst_rfd",   REG_RFD, 0);
    chk("rst_d",     REG_D, 0);
    chk("rst_flag",  REG_Interrupt_flag, 0);
    chk("rst_ack",   IRQ_ack, 0);
    chk("rst_ready", MEM_WB_ready, 0);
    chk("rst_busy",  busy, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_rst", MEM_WB_ready, 1);

    foreach (tbl[i]) begin
      step(tbl[i].uv, tbl[i].ur, tbl[i].ud, tbl[i].mv, tbl[i].mr, tbl[i].md, hs);
      chk($sformatf("v%0d_hs", i), hs, tbl[i].e_hs);
      chk($sformatf("v%0d_w1", i), REG_Write, tbl[i].e_w1);
      idle(hs);
      chk($sformatf("v%0d_w2", i), REG_Write, tbl[i].e_w2);
      idle(hs);
      idle(hs);
    end
    chk("rf9_final", rf[9], 16'h5555);

    // ULA saturates the port while MEM offers three loads.
    k = 0;
    for (int c = 0; c < 6; c++) begin
      step(1'b1, 4'(c + 2), 16'h0100 + 16'(c), 1'b1, 4'(10 + k), 16'hC000 + 16'(k), hs);
      if (hs) k++;
    end
    chk("full_accepts", k, 2);
    chk("full_ready_low", MEM_WB_ready, 0);
    chk("full_busy", busy, 1);
    for (int c = 0; c < 10 && k < 3; c++) begin
      step(1'b0, 4'd0, 16'h0, 1'b1, 4'(10 + k), 16'hC000 + 16'(k), hs);
      if (hs) k++;
    end
    chk("third_accept", k, 3);
    repeat (4) idle(hs);
    chk("order_drained", exq.size(), 0);
    chk("idle_busy", busy, 0);

    // Context entry with two loads queued.
    step(1'b1, 4'd3, 16'h3030, 1'b1, 4'd11, 16'hB011, hs);
    chk("irq_fill0", hs, 1);
    step(1'b1, 4'd3, 16'h3031, 1'b1, 4'd12, 16'hB012, hs);
    chk("irq_fill1", hs, 1);
    IRQ_req = 1'b1;
    lat = 0;
    got = 1'b0;
    for (int c = 1; c <= 20 && !got; c++) begin
      idle(hs);
      if (c == 1) chk("drain_ready_low", MEM_WB_ready, 0);
      if (IRQ_ack) begin
        got = 1'b1;
        lat = c;
      end
    end
    chk("irq_in_lat", lat, 4);
    chk("irq_in_flag", REG_Interrupt_flag, 1);
    chk("irq_in_committed", exq.size(), 0);
    chk("rf12_before_switch", rf[12], 16'hB012);
    acks = 0;
    repeat (3) begin
      idle(hs);
      acks += int'(IRQ_ack);
    end
    chk("firq_no_nest", acks, 0);
    chk("firq_flag_held", REG_Interrupt_flag, 1);
    chk("firq_ready", MEM_WB_ready, 1);
    IRQ_req = 1'b0;
    IRQ_ret = 1'b1;
    lat = 0;
    got = 1'b0;
    for (int c = 1; c <= 20 && !got; c++) begin
      idle(hs);
      if (IRQ_ack) begin
        got = 1'b1;
        lat = c;
      end
    end
    chk("irq_ret_lat", lat, 2);
    chk("irq_ret_flag", REG_Interrupt_flag, 0);
    acks = 0;
    repeat (3) begin
      idle(hs);
      acks += int'(IRQ_ack);
    end
    chk("usr_ret_ignored", acks, 0);
    IRQ_ret = 1'b0;

    // Asynchronous reset in the middle of a drain with a full FIFO.
    step(1'b1, 4'd4, 16'h4444, 1'b1, 4'd13, 16'hD000, hs);
    step(1'b1, 4'd4, 16'h4445, 1'b1, 4'd14, 16'hD001, hs);
    IRQ_req = 1'b1;
    step(1'b1, 4'd4, 16'h4446, 1'b0, 4'd0, 16'h0, hs);
    chk("pre_rst_write", REG_Write, 1);
    chk("pre_rst_busy", busy, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_write", REG_Write, 0);
    chk("mid_rst_rfd",   REG_RFD, 0);
    chk("mid_rst_d",     REG_D, 0);
    chk("mid_rst_flag",  REG_Interrupt_flag, 0);
    chk("mid_rst_ack",   IRQ_ack, 0);
    chk("mid_rst_ready", MEM_WB_ready, 0);
    chk("mid_rst_busy",  busy, 0);
    exq.delete();
    mq.delete();
    IRQ_req      = 1'b0;
    ULA_WB_valid = 1'b0;
    MEM_WB_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_ready", MEM_WB_ready, 1);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_flag", REG_Interrupt_flag, 0);
    for (int c = 0; c < 3; c++) begin
      idle(hs);
      chk($sformatf("post_rst_nowrite%0d", c), REG_Write, 0);
    end
    chk("final_scoreboard_empty", exq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
